// File: rtl/stn_pkg.sv
// Shared types and defaults for the STN LCDC capture front end.
// Included first so both the edge synchroniser and the top can import it.
package stn_pkg;

    typedef enum logic [3:0] {
        LD_W1 = 4'd1,
        LD_W2 = 4'd2,
        LD_W4 = 4'd4,
        LD_W8 = 4'd8
    } ld_width_e;

    localparam int DEF_X_WIDTH = 10;
    localparam int DEF_Y_WIDTH = 9;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        ACTIVE     = 1'b1
    } fsm_state_t;

    function automatic bit ld_width_legal(input int w);
        return (w == int'(LD_W1)) || (w == int'(LD_W2)) ||
               (w == int'(LD_W4)) || (w == int'(LD_W8));
    endfunction

endpackage

// File: rtl/stn_edge_sync.sv
// Multi-flop synchroniser followed by a registered rising-edge strobe.
// Strobe goes high STAGES+1 clocks after the pin rises.
module stn_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [STAGES-1:0] sync;
    logic              last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            last <= 1'b0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            last <= sync[STAGES-1];
            rise <= sync[STAGES-1] & ~last;
        end
    end

endmodule

// File: rtl/stn_capture.sv
// STN LCDC capture: pin oversampling, frame geometry measurement and
// pixel-group stream with coordinates, sof/eol markers, lock and overflow.
module stn_capture
    import stn_pkg::*;
#(
    parameter int LD_WIDTH     = 4,
    parameter bit REVERSE_BITS = 1'b1,
    parameter int X_WIDTH      = DEF_X_WIDTH,
    parameter int Y_WIDTH      = DEF_Y_WIDTH,
    parameter int SYNC_STAGES  = 2,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lflm,
    input  logic                llp,
    input  logic                lck,
    input  logic [LD_WIDTH-1:0] ld,
    output logic                pix_valid,
    output logic [LD_WIDTH-1:0] pix_data,
    output logic [X_WIDTH-1:0]  pix_x,
    output logic [Y_WIDTH-1:0]  pix_y,
    output logic                pix_sof,
    output logic                pix_eol,
    output logic [X_WIDTH-1:0]  frame_width,
    output logic [Y_WIDTH-1:0]  frame_height,
    output logic                geom_locked,
    output logic                err_overflow
);

    if (!ld_width_legal(LD_WIDTH) || SYNC_STAGES < 2) begin : g_bad_param
        $error("stn_capture: illegal LD_WIDTH or SYNC_STAGES");
    end

    localparam int LC_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [X_WIDTH-1:0] X_MAX  = {X_WIDTH{1'b1}};
    localparam logic [Y_WIDTH-1:0] Y_MAX  = {Y_WIDTH{1'b1}};
    localparam logic [X_WIDTH-1:0] X_STEP = X_WIDTH'(LD_WIDTH);
    localparam logic [LC_W-1:0]    LC_MAX = LC_W'(LOCK_FRAMES);

    logic lflm_rise, llp_rise, lck_rise;

    stn_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_lflm (
        .clk(clk), .rst_n(rst_n), .din(lflm), .rise(lflm_rise)
    );
    stn_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_llp (
        .clk(clk), .rst_n(rst_n), .din(llp), .rise(llp_rise)
    );
    stn_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_lck (
        .clk(clk), .rst_n(rst_n), .din(lck), .rise(lck_rise)
    );

    // One extra stage over the control sync so data lines up with the strobe
    logic [LD_WIDTH-1:0] ld_pipe [SYNC_STAGES+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= SYNC_STAGES; i++) ld_pipe[i] <= '0;
        end else begin
            ld_pipe[0] <= ld;
            for (int i = 1; i <= SYNC_STAGES; i++) ld_pipe[i] <= ld_pipe[i-1];
        end
    end

    logic [LD_WIDTH-1:0] grp;

    always_comb begin
        grp = '0;
        for (int i = 0; i < LD_WIDTH; i++) begin
            grp[i] = REVERSE_BITS ? ld_pipe[SYNC_STAGES][LD_WIDTH-1-i]
                                  : ld_pipe[SYNC_STAGES][i];
        end
    end

    fsm_state_t         state;
    logic [X_WIDTH-1:0] x, x_n, fw_n, prev_w;
    logic [Y_WIDTH-1:0] y, y_n, fh_n, prev_h;
    logic [LC_W-1:0]    lock_cnt, lock_n;
    logic               sof_arm, arm_n, ovf_n;

    // Same-cycle edges resolve in order lck, llp, lflm
    always_comb begin
        x_n    = x;
        y_n    = y;
        fw_n   = frame_width;
        fh_n   = frame_height;
        ovf_n  = err_overflow;
        arm_n  = sof_arm;
        lock_n = lock_cnt;
        if (lck_rise) begin
            arm_n = 1'b0;
            if (x > X_MAX - X_STEP) begin
                x_n   = X_MAX;
                ovf_n = 1'b1;
            end else begin
                x_n = x + X_STEP;
            end
        end
        if (llp_rise) begin
            if (x_n != '0) fw_n = x_n;
            x_n = '0;
            if (y == Y_MAX) ovf_n = 1'b1;
            else y_n = y + 1'b1;
        end
        if (lflm_rise) begin
            if (y_n != '0) fh_n = y_n;
            y_n   = '0;
            arm_n = 1'b1;
            ovf_n = 1'b0;
            if ({fw_n, fh_n} == {prev_w, prev_h}) begin
                if (lock_cnt != LC_MAX) lock_n = lock_cnt + 1'b1;
            end else begin
                lock_n = LC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WAIT_FRAME;
            x            <= '0;
            y            <= '0;
            prev_w       <= '0;
            prev_h       <= '0;
            lock_cnt     <= '0;
            sof_arm      <= 1'b0;
            pix_valid    <= 1'b0;
            pix_data     <= '0;
            pix_x        <= '0;
            pix_y        <= '0;
            pix_sof      <= 1'b0;
            pix_eol      <= 1'b0;
            frame_width  <= '0;
            frame_height <= '0;
            geom_locked  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            unique case (state)
                WAIT_FRAME: begin
                    if (lflm_rise) begin
                        state   <= ACTIVE;
                        sof_arm <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (lck_rise) begin
                        pix_valid <= 1'b1;
                        pix_data  <= grp;
                        pix_x     <= x;
                        pix_y     <= y;
                        pix_sof   <= sof_arm;
                    end
                    pix_eol      <= llp_rise;
                    x            <= x_n;
                    y            <= y_n;
                    sof_arm      <= arm_n;
                    frame_width  <= fw_n;
                    frame_height <= fh_n;
                    err_overflow <= ovf_n;
                    lock_cnt     <= lock_n;
                    geom_locked  <= (lock_n == LC_MAX);
                    if (lflm_rise) begin
                        prev_w <= fw_n;
                        prev_h <= fh_n;
                    end
                end
                default: state <= WAIT_FRAME;
            endcase
        end
    end

endmodule
